// File: rtl/sal_ddr2_pkg.sv
// Shared AXI burst encodings and the burst-legality rule used by the address-channel arbiter.
package sal_ddr2_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    // A WRAP burst must span 2, 4, 8 or 16 beats; alen encodes beats-1.
    function automatic logic wrap_len_ok(input int unsigned alen);
        return (alen == 1) || (alen == 3) || (alen == 7) || (alen == 15);
    endfunction

    function automatic logic burst_illegal(input logic [1:0] burst, input int unsigned alen);
        return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok(alen));
    endfunction

endpackage

// File: rtl/axi_a_skid_fifo.sv
// Two-entry buffer between the arbiter and the downstream address channel.
module axi_a_skid_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              pop;
    logic [DATA_W-1:0] mem [2];

    // Readiness comes from registered occupancy only, so a downstream pop never frees a slot in the same cycle.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axi_a_arbiter.sv
// Round-robin merge of NUM_PORTS AXI address channels into one, tagging IDs with the source port.
module axi_a_arbiter
    import sal_ddr2_pkg::*;
#(
    parameter  int NUM_PORTS    = 2,
    parameter  int ADDR_WIDTH   = 32,
    parameter  int ID_WIDTH     = 4,
    parameter  int ADDR_LEN     = 4,
    localparam int PORT_BITS    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int OUT_ID_WIDTH = ID_WIDTH + PORT_BITS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 s_avalid,
    output logic [NUM_PORTS-1:0]                 s_aready,
    input  logic [NUM_PORTS-1:0]                 s_awrite,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   s_aid,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] s_aaddr,
    input  logic [NUM_PORTS-1:0][ADDR_LEN-1:0]   s_alen,
    input  logic [NUM_PORTS-1:0][2:0]            s_asize,
    input  logic [NUM_PORTS-1:0][1:0]            s_aburst,
    output logic                                 m_avalid,
    input  logic                                 m_aready,
    output logic                                 m_awrite,
    output logic [OUT_ID_WIDTH-1:0]              m_aid,
    output logic [ADDR_WIDTH-1:0]                m_aaddr,
    output logic [ADDR_LEN-1:0]                  m_alen,
    output logic [2:0]                           m_asize,
    output logic [1:0]                           m_aburst,
    output logic                                 err_burst,
    output logic [PORT_BITS-1:0]                 err_port,
    input  logic                                 err_clr
);

    localparam int DATA_W = 1 + OUT_ID_WIDTH + ADDR_WIDTH + ADDR_LEN + 3 + 2;

    logic [PORT_BITS-1:0] rr_ptr;
    logic [PORT_BITS-1:0] gnt_idx;
    logic [PORT_BITS-1:0] rr_nxt;
    logic                 gnt_vld;
    logic                 fifo_rdy;
    logic                 acc;
    logic                 bad_burst;
    logic [DATA_W-1:0]    push_data;
    logic [DATA_W-1:0]    head_data;

    function automatic logic [PORT_BITS-1:0] port_at(input logic [PORT_BITS-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_PORTS) sum -= NUM_PORTS;
        return PORT_BITS'(sum);
    endfunction

    // Scan from farthest to nearest so the first valid port at or after rr_ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (s_avalid[port_at(rr_ptr, k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = port_at(rr_ptr, k);
            end
        end
    end

    // rst_n gates readiness so no port sees an accept while reset is held.
    assign acc       = gnt_vld & fifo_rdy & rst_n;
    assign s_aready  = acc ? (NUM_PORTS'(1) << gnt_idx) : '0;
    assign rr_nxt    = (gnt_idx == PORT_BITS'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    assign bad_burst = burst_illegal(s_aburst[gnt_idx], 32'(s_alen[gnt_idx]));

    assign push_data = {s_awrite[gnt_idx], gnt_idx, s_aid[gnt_idx], s_aaddr[gnt_idx],
                        s_alen[gnt_idx], s_asize[gnt_idx], s_aburst[gnt_idx]};
    assign {m_awrite, m_aid, m_aaddr, m_alen, m_asize, m_aburst} = head_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            err_burst <= 1'b0;
            err_port  <= '0;
        end else begin
            if (acc) rr_ptr <= rr_nxt;
            // A fresh illegal accept overrides a simultaneous clear and re-captures its port.
            if (acc && bad_burst) begin
                err_burst <= 1'b1;
                if (!err_burst || err_clr) err_port <= gnt_idx;
            end else if (err_clr) begin
                err_burst <= 1'b0;
                err_port  <= '0;
            end
        end
    end

    axi_a_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (acc),
        .push_data (push_data),
        .in_ready  (fifo_rdy),
        .out_valid (m_avalid),
        .out_ready (m_aready),
        .out_data  (head_data)
    );

endmodule

// File: doc/axi_a_arbiter.md
AXI_A_ARBITER -- requirements
Module: axi_a_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of upstream merged address channels (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, address width.
REQ-003 Parameter ID_WIDTH, default 4, upstream ID width.
REQ-004 Parameter ADDR_LEN, default 4, burst length field width.
REQ-005 Localparam PORT_BITS = max(1, clog2(NUM_PORTS)); OUT_ID_WIDTH = ID_WIDTH + PORT_BITS.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 s_avalid  in  NUM_PORTS  per-port request valid.
REQ-010 s_aready  out  NUM_PORTS  per-port accept.
REQ-011 s_awrite  in  NUM_PORTS  per-port direction, 1 = write (AW), 0 = read (AR).
REQ-012 s_aid  in  NUM_PORTS x ID_WIDTH  per-port ID.
REQ-013 s_aaddr  in  NUM_PORTS x ADDR_WIDTH  per-port address.
REQ-014 s_alen / s_asize / s_aburst  in  NUM_PORTS x ADDR_LEN / 3 / 2  per-port burst attributes.
REQ-015 m_avalid  out  1; m_aready  in  1  downstream handshake.
REQ-016 m_awrite  out  1; m_aid  out  OUT_ID_WIDTH  {port index, s_aid}.
REQ-017 m_aaddr / m_alen / m_asize / m_aburst  out  ADDR_WIDTH / ADDR_LEN / 3 / 2.
REQ-018 err_burst  out  1  sticky illegal-burst flag.
REQ-019 err_port  out  PORT_BITS  port of first illegal burst since last clear.
REQ-020 err_clr  in  1  synchronous clear of err_burst/err_port.

Function
REQ-021 Arbitration SHALL be round-robin: grant goes to the first valid port at or after rr_ptr, wrapping modulo NUM_PORTS.
REQ-022 s_aready[i] SHALL be 1 only for the granted port, only while buffer occupancy < 2; no combinational path from m_aready to s_aready.
REQ-023 On accept (s_avalid[i] & s_aready[i]) rr_ptr SHALL become (i+1) mod NUM_PORTS; otherwise rr_ptr holds.
REQ-024 A non-granted valid port SHALL wait at most NUM_PORTS-1 accepts before grant.
REQ-025 Accepted requests SHALL enter a 2-entry FIFO; m_* SHALL present the head entry; m_avalid = (occupancy != 0).
REQ-026 Latency: request accepted at edge N SHALL be visible on m_* after edge N (cycle N+1) when FIFO was empty.
REQ-027 Push and pop on the same edge SHALL leave occupancy unchanged; sustained throughput 1 request/cycle when m_aready held high.
REQ-028 When occupancy == 2 all s_aready SHALL be 0, even if m_aready = 1 that cycle.
REQ-029 m_* SHALL remain stable while m_avalid & ~m_aready.
REQ-030 m_aid SHALL equal {port index[PORT_BITS-1:0], s_aid}; ordering within the FIFO SHALL equal accept order.
REQ-031 Illegal burst: aburst == 2'b11, or aburst == 2'b10 (WRAP) with alen+1 not in {2,4,8,16}; checked on accept.
REQ-032 Illegal bursts SHALL still be forwarded unchanged; err_burst set, err_port loaded only if err_burst was 0.
REQ-033 err_clr and a new illegal accept on the same edge: set wins; err_port loaded with new port.

Reset
REQ-034 On rst_n low: occupancy 0, rr_ptr 0, err_burst 0, err_port 0, m_avalid 0, s_aready all 0 during reset.
REQ-035 Reset mid-transfer SHALL discard buffered requests; no output handshake after reset release until a new accept.
REQ-036 FIFO data storage need not be reset; outputs other than m_avalid and err_* are don't-care while m_avalid = 0.

Structure
REQ-037 Burst encodings (FIXED 2'b00, INCR 2'b01, WRAP 2'b10, RSVD 2'b11) and the legal WRAP length check SHALL live in the shared SAL_DDR2 package.
REQ-038 The 2-entry buffer SHALL be a separate sub-module axi_a_skid_fifo, parametrised by payload width.
REQ-039 Arbiter, pointer and error logic SHALL stay in axi_a_arbiter.

Verification
REQ-040 Ports 0,1 both valid constantly, m_aready = 1 -> m_aid port bits alternate 0,1,0,1; one output per cycle.
REQ-041 Port 1 only, addr 0x100, len 3, INCR, write -> m_avalid cycle after accept, m_aid = {1, id}, m_awrite = 1.
REQ-042 m_aready = 0, three requests offered -> two accepted, third s_aready = 0 until m_aready = 1 pops one.
REQ-043 Port 0 WRAP len 2 -> forwarded; err_burst = 1, err_port = 0; later port 1 RSVD -> err_port stays 0; err_clr -> both 0.
REQ-044 rst_n asserted with 2 entries buffered -> m_avalid = 0 immediately; after release no output until new accept.
REQ-045 NUM_PORTS = 4, ports 1 and 3 valid, rr_ptr = 2 -> port 3 granted first, then 1.
